// File: rtl/button_event.sv
// Classifies a debounced button level into press/release edges and
// short-press, long-press and double-click event pulses.
module button_event #(
    parameter int unsigned CNT_W    = 26,
    parameter int unsigned LONG_CNT = 38000000,
    parameter int unsigned DBL_CNT  = 11400000
) (
    input  logic clk,
    input  logic reset,
    input  logic db_in,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_click
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CNT - 1);

    state_t           state;
    logic             db_q;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             fall;

    // Edges are suppressed until the button has been seen released after reset,
    // so a button held through reset cannot fire a spurious press.
    assign rise = armed & db_in & ~db_q;
    assign fall = armed & ~db_in & db_q;
    assign held = db_q;

    // NOTE: every register here is updated with <= so that all branches read
    // the pre-edge values; the later cnt <= '0 in a branch overrides the default.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            db_q          <= 1'b0;
            armed         <= 1'b0;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            double_click  <= 1'b0;
        end else begin
            db_q          <= db_in;
            press_pulse   <= rise;
            release_pulse <= fall;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            double_click  <= 1'b0;
            if (!db_in) begin
                armed <= 1'b1;
            end
            if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Edges take priority over the counter thresholds.
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= PRESS1;
                        cnt   <= '0;
                    end
                end
                PRESS1: begin
                    if (fall) begin
                        state <= WAIT2;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= LONG;
                        cnt        <= '0;
                        long_press <= 1'b1;
                    end
                end
                WAIT2: begin
                    if (rise) begin
                        state <= PRESS2;
                        cnt   <= '0;
                    end else if (cnt == DBL_LAST) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        short_press <= 1'b1;
                    end
                end
                PRESS2: begin
                    if (fall) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        double_click <= 1'b1;
                    end else if (cnt == LONG_LAST) begin
                        state      <= LONG;
                        cnt        <= '0;
                        long_press <= 1'b1;
                    end
                end
                LONG: begin
                    if (fall) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_CNT = 20, DBL_CNT = 10, CNT_W = 8:
// table of press waveforms with hand-computed pulse counts and times.
module tb_button_event;

    logic clk;
    logic reset;
    logic db_in;
    logic held;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic double_click;

    int n_checks;
    int n_errors;

    button_event #(
        .CNT_W   (8),
        .LONG_CNT(20),
        .DBL_CNT (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .db_in        (db_in),
        .held         (held),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waveform: high for p1 edges, low for gap, high for p2 (if p2 > 0), then low.
    // Times are "edge index + 1", i.e. the cycle in which the output is visible,
    // with the first press edge as edge 0.
    typedef struct {
        int p1;
        int gap;
        int p2;
        int n_press;
        int n_rel;
        int n_short;
        int n_long;
        int n_dbl;
        int t_press;
        int t_rel;
        int t_short;
        int t_long;
        int t_dbl;
    } vec_t;

    localparam int WINDOW = 60;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive db_in for one rising edge; returns at the following falling edge,
    // where outputs produced by that edge are stable.
    task automatic tick(input logic d);
        db_in = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic wave(input int k, input vec_t v);
        if (k < v.p1) return 1'b1;
        if (v.p2 > 0 && k >= v.p1 + v.gap && k < v.p1 + v.gap + v.p2) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int c_press, c_rel, c_short, c_long, c_dbl;
        int f_press, f_rel, f_short, f_long, f_dbl;
        int held_bad, overlap;
        c_press = 0; c_rel = 0; c_short = 0; c_long = 0; c_dbl = 0;
        f_press = 0; f_rel = 0; f_short = 0; f_long = 0; f_dbl = 0;
        held_bad = 0; overlap = 0;
        for (int k = 0; k < WINDOW; k++) begin
            tick(wave(k, v));
            if (held !== db_in) held_bad++;
            if (press_pulse)   begin c_press++; if (f_press == 0) f_press = k + 1; end
            if (release_pulse) begin c_rel++;   if (f_rel == 0)   f_rel   = k + 1; end
            if (short_press)   begin c_short++; if (f_short == 0) f_short = k + 1; end
            if (long_press)    begin c_long++;  if (f_long == 0)  f_long  = k + 1; end
            if (double_click)  begin c_dbl++;   if (f_dbl == 0)   f_dbl   = k + 1; end
            if (int'(short_press) + int'(long_press) + int'(double_click) > 1) overlap++;
        end
        check($sformatf("v%0d press count", idx),   c_press, v.n_press);
        check($sformatf("v%0d release count", idx), c_rel,   v.n_rel);
        check($sformatf("v%0d short count", idx),   c_short, v.n_short);
        check($sformatf("v%0d long count", idx),    c_long,  v.n_long);
        check($sformatf("v%0d double count", idx),  c_dbl,   v.n_dbl);
        check($sformatf("v%0d press time", idx),    f_press, v.t_press);
        check($sformatf("v%0d release time", idx),  f_rel,   v.t_rel);
        check($sformatf("v%0d short time", idx),    f_short, v.t_short);
        check($sformatf("v%0d long time", idx),     f_long,  v.t_long);
        check($sformatf("v%0d double time", idx),   f_dbl,   v.t_dbl);
        check($sformatf("v%0d held lag errors", idx), held_bad, 0);
        check($sformatf("v%0d class overlap", idx),   overlap, 0);
    endtask

    function automatic int outs();
        return int'({held, press_pulse, release_pulse, short_press, long_press, double_click});
    endfunction

    vec_t vecs[8];
    int   cnt_any;

    initial begin
        n_checks = 0;
        n_errors = 0;
        //           p1 gap p2  np nr ns nl nd  tp tr  ts  tl  td
        vecs[0] = '{ 5,  0,  0,  1, 1, 1, 0, 0,  1,  6, 16,  0,  0}; // short press
        vecs[1] = '{30,  0,  0,  1, 1, 0, 1, 0,  1, 31,  0, 21,  0}; // long press
        vecs[2] = '{ 5,  4,  5,  2, 2, 0, 0, 1,  1,  6,  0,  0, 15}; // double click
        vecs[3] = '{ 5,  4, 25,  2, 2, 0, 1, 0,  1,  6,  0, 30,  0}; // second press goes long
        vecs[4] = '{20,  0,  0,  1, 1, 1, 0, 0,  1, 21, 31,  0,  0}; // release at cnt == 19
        vecs[5] = '{21,  0,  0,  1, 1, 0, 1, 0,  1, 22,  0, 21,  0}; // one cycle later: long
        vecs[6] = '{ 5, 10,  5,  2, 2, 0, 0, 1,  1,  6,  0,  0, 21}; // rise at cnt == 9
        vecs[7] = '{ 5, 11,  5,  2, 2, 2, 0, 0,  1,  6, 16,  0,  0}; // one cycle later: two shorts

        // Reset with the button held through it, then released: no events.
        reset = 1'b1;
        db_in = 1'b1;
        @(negedge clk);
        tick(1'b1);
        tick(1'b1);
        check("reset outputs zero", outs(), 0);
        reset = 1'b0;
        cnt_any = 0;
        for (int k = 0; k < 50; k++) begin
            tick(1'b1);
            if (press_pulse | release_pulse | short_press | long_press | double_click) cnt_any++;
        end
        check("held high after hold", int'(held), 1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0);
            if (press_pulse | release_pulse | short_press | long_press | double_click) cnt_any++;
        end
        check("no pulses while unarmed", cnt_any, 0);
        check("press pulse low before press", int'(press_pulse), 0);
        tick(1'b1);
        check("first armed press pulse", int'(press_pulse), 1);
        for (int k = 0; k < 4; k++) tick(1'b1);
        for (int k = 0; k < 40; k++) tick(1'b0);

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
            for (int k = 0; k < 10; k++) tick(1'b0);
        end

        // Reset in the middle of WAIT2 drops the pending short press.
        for (int k = 0; k < 5; k++) tick(1'b1);
        for (int k = 0; k < 4; k++) tick(1'b0);
        reset = 1'b1;
        tick(1'b0);
        check("outputs zero after mid-wait reset", outs(), 0);
        reset = 1'b0;
        cnt_any = 0;
        for (int k = 0; k < 30; k++) begin
            tick(1'b0);
            if (short_press | long_press | double_click) cnt_any++;
        end
        check("no class pulse after reset", cnt_any, 0);
        tick(1'b1);
        check("press after mid-wait reset", int'(press_pulse), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
